// File: rtl/uart_fifo.sv
// Memory-mapped UART with TX/RX FIFOs, programmable frame format and runtime baud divider.
// Level IRQs on TX drained and RX watermark/error; read data is registered one cycle after the strobe.
module uart_fifo #(
  parameter logic [31:0] ADDR_BASE = 32'h0,
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 8,
  parameter logic [15:0] BAUD_RST  = 16'd86
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] uart_r_addr_i,
  input  logic [31:0] uart_w_addr_i,
  input  logic [31:0] uart_data_i,
  input  logic        uart_r_enable_i,
  input  logic        uart_w_enable_i,
  output logic [31:0] uart_data_o,
  output logic        tx,
  input  logic        rx,
  output logic        uart_tx_irq,
  output logic        uart_rx_irq
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TCW = TAW + 1;
  localparam int RCW = RAW + 1;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BREAK} rx_state_t;

  function automatic logic [7:0] dmask(input logic [1:0] dbits);
    case (dbits)
      2'd0:    return 8'h1F;
      2'd1:    return 8'h3F;
      2'd2:    return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

  logic [31:0] r_off, w_off;
  logic        wr_txdata, wr_ctrl, wr_status, wr_baud, rd_rxdata;
  logic [11:0] ctrl;
  logic [15:0] baud;
  logic [3:0]  sticky;
  logic [31:0] status;
  logic        tx_en, rx_en, par_en, stop2;
  logic [1:0]  dbits;
  logic [2:0]  last_idx;
  logic        unused_bits;

  assign r_off     = uart_r_addr_i - ADDR_BASE;
  assign w_off     = uart_w_addr_i - ADDR_BASE;
  assign wr_txdata = uart_w_enable_i && (w_off == 32'h0);
  assign wr_ctrl   = uart_w_enable_i && (w_off == 32'h8);
  assign wr_status = uart_w_enable_i && (w_off == 32'hC);
  assign wr_baud   = uart_w_enable_i && (w_off == 32'h10);
  assign rd_rxdata = uart_r_enable_i && (r_off == 32'h4);
  assign tx_en     = ctrl[0];
  assign rx_en     = ctrl[1];
  assign dbits     = ctrl[5:4];
  assign par_en    = ctrl[7];
  assign stop2     = ctrl[8];
  assign last_idx  = 3'(dbits) + 3'd4;
  assign unused_bits = ^uart_data_i[31:16];

  // TX FIFO
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_wp, tx_rp;
  logic [TCW-1:0] tx_count;
  logic           tx_empty, tx_full, tx_push, tx_pop;

  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == TCW'(TX_DEPTH));
  assign tx_push  = wr_txdata && (!tx_full || tx_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= uart_data_i[7:0] & dmask(dbits);
  end

  // RX FIFO
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wp, rx_rp;
  logic [RCW-1:0] rx_count;
  logic           rx_empty, rx_full, rx_push, rx_pop, rx_push_req;
  logic [7:0]     rx_data;

  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == RCW'(RX_DEPTH));
  assign rx_pop   = rd_rxdata && !rx_empty;
  assign rx_push  = rx_push_req && (!rx_full || rx_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_data;
  end

  // TX FSM
  tx_state_t  tx_state, tx_state_nx;
  logic [15:0] tx_cnt, tx_per;
  logic [2:0]  tx_idx;
  logic        tx_stop_idx, tx_tick, tx_d, tx_par;
  logic [7:0]  tx_shift;

  assign tx_tick = (tx_cnt == tx_per);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_state_nx;
  end

  always_comb begin
    tx_state_nx = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_en && !tx_empty) tx_state_nx = TX_START;
      TX_START: if (tx_tick) tx_state_nx = TX_DATA;
      TX_DATA:  if (tx_tick && tx_idx == last_idx) tx_state_nx = par_en ? TX_PAR : TX_STOP;
      TX_PAR:   if (tx_tick) tx_state_nx = TX_STOP;
      TX_STOP:  if (tx_tick && tx_stop_idx == stop2) tx_state_nx = TX_IDLE;
      default:  tx_state_nx = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_pop = 1'b0;
    tx_d   = 1'b1;
    case (tx_state)
      TX_IDLE:  tx_pop = tx_en && !tx_empty;
      TX_START: tx_d   = 1'b0;
      TX_DATA:  tx_d   = tx_shift[0];
      TX_PAR:   tx_d   = tx_par;
      default:  tx_d   = 1'b1;
    endcase
  end

  // Bit period is re-latched at every bit boundary so BAUD changes land cleanly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx          <= 1'b1;
      tx_cnt      <= '0;
      tx_per      <= BAUD_RST;
      tx_idx      <= '0;
      tx_stop_idx <= 1'b0;
    end else begin
      tx <= tx_d;
      if (tx_state == TX_IDLE) begin
        tx_cnt      <= '0;
        tx_per      <= baud;
        tx_idx      <= '0;
        tx_stop_idx <= 1'b0;
      end else if (tx_tick) begin
        tx_cnt <= '0;
        tx_per <= baud;
        if (tx_state == TX_DATA) tx_idx <= tx_idx + 1'b1;
        if (tx_state == TX_STOP) tx_stop_idx <= 1'b1;
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_pop) begin
      tx_shift <= tx_mem[tx_rp];
      tx_par   <= ^(tx_mem[tx_rp] & dmask(dbits)) ^ ctrl[6];
    end else if (tx_state == TX_DATA && tx_tick) begin
      tx_shift <= tx_shift >> 1;
    end
  end

  // RX synchroniser: p1 is the synchronised line, p2 its previous value for edge detect
  logic rx_p0, rx_p1, rx_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  // RX FSM
  rx_state_t   rx_state, rx_state_nx;
  logic [15:0] rx_cnt, rx_per;
  logic [2:0]  rx_idx;
  logic        rx_tick, rx_half, rx_par_bad, frm_set, par_set;
  logic [7:0]  rx_shift;

  assign rx_tick = (rx_cnt == rx_per);
  assign rx_half = (rx_cnt == (rx_per >> 1));
  assign rx_data = rx_shift >> (3'd3 - 3'(dbits));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_state_nx;
  end

  always_comb begin
    rx_state_nx = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_en && rx_p2 && !rx_p1) rx_state_nx = RX_START;
      RX_START: if (rx_half) rx_state_nx = rx_p1 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_idx == last_idx) rx_state_nx = par_en ? RX_PAR : RX_STOP;
      RX_PAR:   if (rx_tick) rx_state_nx = RX_STOP;
      RX_STOP:  if (rx_tick) rx_state_nx = rx_p1 ? RX_IDLE : RX_BREAK;
      RX_BREAK: if (rx_p1) rx_state_nx = RX_IDLE;
      default:  rx_state_nx = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_push_req = 1'b0;
    frm_set     = 1'b0;
    par_set     = 1'b0;
    if (rx_state == RX_STOP && rx_tick) begin
      if (!rx_p1)          frm_set     = 1'b1;
      else if (rx_par_bad) par_set     = 1'b1;
      else                 rx_push_req = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt     <= '0;
      rx_per     <= BAUD_RST;
      rx_idx     <= '0;
      rx_par_bad <= 1'b0;
    end else begin
      if (rx_state == RX_IDLE || rx_state == RX_BREAK) begin
        rx_cnt     <= '0;
        rx_per     <= baud;
        rx_idx     <= '0;
        rx_par_bad <= 1'b0;
      end else if (rx_state == RX_START ? rx_half : rx_tick) begin
        rx_cnt <= '0;
        rx_per <= baud;
        if (rx_state == RX_DATA) rx_idx <= rx_idx + 1'b1;
        if (rx_state == RX_PAR)  rx_par_bad <= rx_p1 != (^rx_data ^ ctrl[6]);
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_state == RX_DATA && rx_tick) rx_shift <= {rx_p1, rx_shift[7:1]};
  end

  // Register file, sticky status and IRQs
  assign status = {8'h00, 8'(tx_count), 8'(rx_count), sticky, rx_full, tx_full, !rx_empty,
                   tx_state != TX_IDLE};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl        <= '0;
      baud        <= BAUD_RST;
      sticky      <= '0;
      uart_tx_irq <= 1'b0;
      uart_rx_irq <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= uart_data_i[11:0];
      if (wr_baud) baud <= uart_data_i[15:0];
      sticky <= (wr_status ? (sticky & ~uart_data_i[7:4]) : sticky) |
                {wr_txdata && !tx_push, rx_push_req && !rx_push, frm_set, par_set};
      uart_tx_irq <= ctrl[2] && tx_empty && (tx_state == TX_IDLE);
      uart_rx_irq <= ctrl[3] && ((int'(rx_count) > int'(ctrl[11:9])) || (|sticky[2:0]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_data_o <= '0;
    end else begin
      uart_data_o <= '0;
      if (uart_r_enable_i) begin
        case (r_off)
          32'h4:   uart_data_o <= rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rp] & dmask(dbits)};
          32'h8:   uart_data_o <= {20'h0, ctrl};
          32'hC:   uart_data_o <= status;
          32'h10:  uart_data_o <= {16'h0, baud};
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: register table plus hand-built TX, loopback, error and reset sequences.
module tb_uart_fifo;
  localparam logic [31:0] BASE = 32'h0000_4000;
  localparam logic [31:0] A_TX = BASE + 32'h0;
  localparam logic [31:0] A_RX = BASE + 32'h4;
  localparam logic [31:0] A_CT = BASE + 32'h8;
  localparam logic [31:0] A_ST = BASE + 32'hC;
  localparam logic [31:0] A_BD = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] r_addr = '0, w_addr = '0, w_data = '0;
  logic        r_en = 1'b0, w_en = 1'b0;
  logic [31:0] data_o;
  logic        tx, tx_irq, rx_irq;
  logic        rx_drv = 1'b1, loop = 1'b0;
  logic        rx_line;

  assign rx_line = loop ? tx : rx_drv;

  uart_fifo #(.ADDR_BASE(BASE), .TX_DEPTH(8), .RX_DEPTH(8), .BAUD_RST(16'd86)) dut (
    .clk(clk), .rst_n(rst_n),
    .uart_r_addr_i(r_addr), .uart_w_addr_i(w_addr), .uart_data_i(w_data),
    .uart_r_enable_i(r_en), .uart_w_enable_i(w_en), .uart_data_o(data_o),
    .tx(tx), .rx(rx_line), .uart_tx_irq(tx_irq), .uart_rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    w_addr = a; w_data = d; w_en = 1'b1;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    r_addr = a; r_en = 1'b1;
    @(negedge clk);
    r_en = 1'b0;
    d = data_o;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(nm, d, exp);
  endtask

  // One serial bit is 4 clocks at BAUD=3
  task automatic drive_bit(input logic b);
    @(negedge clk);
    rx_drv = b;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit has_par, input bit pb, input bit sb);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (has_par) drive_bit(pb);
    drive_bit(sb);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    bit          do_wr;
    logic [7:0]  woff;
    logic [31:0] wdata;
    logic [7:0]  roff;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[10];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0]  frame;
    logic [31:0] d;
    bit          ok;
    int          lat;

    vt[0] = '{1'b0, 8'h00, 32'h0,         8'h08, 32'h0};
    vt[1] = '{1'b0, 8'h00, 32'h0,         8'h10, 32'd86};
    vt[2] = '{1'b0, 8'h00, 32'h0,         8'h0C, 32'h0};
    vt[3] = '{1'b0, 8'h00, 32'h0,         8'h04, 32'h0};
    vt[4] = '{1'b0, 8'h00, 32'h0,         8'h00, 32'h0};
    vt[5] = '{1'b1, 8'h08, 32'hFFFF_FFFF, 8'h08, 32'h0000_0FFF};
    vt[6] = '{1'b1, 8'h08, 32'h0,         8'h08, 32'h0};
    vt[7] = '{1'b1, 8'h10, 32'h1234_ABCD, 8'h10, 32'h0000_ABCD};
    vt[8] = '{1'b0, 8'h00, 32'h0,         8'h14, 32'h0};
    vt[9] = '{1'b1, 8'h10, 32'h3,         8'h10, 32'h3};

    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_data_o", data_o, 0);
    check("rst_tx_irq", tx_irq, 0);
    check("rst_rx_irq", rx_irq, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      if (vt[i].do_wr) wr(BASE + 32'(vt[i].woff), vt[i].wdata);
      rd(BASE + 32'(vt[i].roff), d);
      check($sformatf("vec%0d", i), d, vt[i].exp);
    end

    // T1: 8N1 frame of 0xA5 at BAUD=3
    wr(A_CT, 32'h35);
    @(negedge clk);
    check("t1_irq_idle", tx_irq, 1);
    wr(A_TX, 32'hA5);
    lat = 0;
    while (tx !== 1'b0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("t1_start_lat", lat, 2);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      ok = 1'b1;
      for (int j = 0; j < 4; j++) begin
        if (k != 0 || j != 0) @(negedge clk);
        if (tx !== frame[k]) ok = 1'b0;
        if (k == 9 && j == 3) check("t1_irq_in_stop", tx_irq, 0);
      end
      check($sformatf("t1_bit%0d", k), ok, 1);
    end
    @(negedge clk);
    check("t1_irq_after", tx_irq, 1);
    check("t1_tx_idle", tx, 1);
    wr(A_TX, 32'h00);
    repeat (4) @(negedge clk);
    rd_chk("t1_busy", A_ST, 32'h0000_0001);
    lat = 0;
    while (tx_irq !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("t1_irq_end", tx_irq, 1);

    // T2: overfill TX FIFO while disabled
    wr(A_CT, 32'h30);
    for (int i = 0; i < 9; i++) wr(A_TX, 32'(i));
    rd_chk("t2_full_ovf", A_ST, 32'h0008_0084);
    wr(A_ST, 32'h80);
    rd_chk("t2_w1c", A_ST, 32'h0008_0004);
    wr(A_BD, 32'h0);
    wr(A_CT, 32'h35);
    lat = 0;
    while (tx_irq !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check("t2_drained_irq", tx_irq, 1);
    rd_chk("t2_status_empty", A_ST, 32'h0);
    wr(A_BD, 32'h3);

    // T3: 7E1 loopback
    loop = 1'b1;
    wr(A_CT, 32'hA3);
    wr(A_TX, 32'h55);
    wr(A_TX, 32'h2A);
    repeat (130) @(negedge clk);
    rd_chk("t3_status", A_ST, 32'h0000_0202);
    rd_chk("t3_rx0", A_RX, 32'h55);
    rd_chk("t3_rx1", A_RX, 32'h2A);
    rd_chk("t3_rx_empty", A_RX, 32'h0);
    @(negedge clk);
    check("t3_data_o_idle", data_o, 0);
    loop = 1'b0;
    wr(A_CT, 32'h0);

    // T4: 8O1 parity error, framing error with break, then a good frame
    wr(A_CT, 32'hF2);
    send_frame(8'h01, 1'b1, 1'b1, 1'b1);
    idle(8);
    rd_chk("t4_par", A_ST, 32'h0000_0010);
    send_frame(8'h03, 1'b1, 1'b1, 1'b0);
    repeat (12) @(negedge clk);
    idle(8);
    rd_chk("t4_frm", A_ST, 32'h0000_0030);
    wr(A_ST, 32'hF0);
    rd_chk("t4_clear", A_ST, 32'h0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    idle(8);
    rd_chk("t4_rearm_status", A_ST, 32'h0000_0102);
    rd_chk("t4_rearm_data", A_RX, 32'h3C);

    // T5: RX overrun with watermark IRQ
    wr(A_CT, 32'hE3A);
    send_frame(8'h10, 1'b0, 1'b0, 1'b1);
    idle(4);
    check("t5_irq_below_wm", rx_irq, 0);
    for (int i = 1; i < 8; i++) begin
      send_frame(8'(8'h10 + i), 1'b0, 1'b0, 1'b1);
      idle(2);
    end
    idle(4);
    check("t5_irq_wm", rx_irq, 1);
    rd_chk("t5_full", A_ST, 32'h0000_080A);
    send_frame(8'h18, 1'b0, 1'b0, 1'b1);
    idle(4);
    rd_chk("t5_ovr", A_ST, 32'h0000_084A);
    check("t5_irq_ovr", rx_irq, 1);
    for (int i = 0; i < 8; i++) rd_chk($sformatf("t5_rx%0d", i), A_RX, 32'(8'h10 + i));
    rd_chk("t5_sticky_only", A_ST, 32'h0000_0040);
    wr(A_ST, 32'h40);
    repeat (2) @(negedge clk);
    check("t5_irq_clear", rx_irq, 0);

    // T6: reset mid-frame, then a one-clock rx glitch
    wr(A_CT, 32'h31);
    wr(A_TX, 32'h00);
    wr(A_TX, 32'h00);
    repeat (12) @(negedge clk);
    check("t6_tx_low", tx, 0);
    rst_n = 1'b0;
    #1;
    check("t6_tx_async", tx, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_chk("t6_ctrl", A_CT, 32'h0);
    rd_chk("t6_baud", A_BD, 32'd86);
    rd_chk("t6_status", A_ST, 32'h0);
    wr(A_CT, 32'h32);
    @(negedge clk);
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (100) @(negedge clk);
    rd_chk("t6_glitch", A_ST, 32'h0);
    check("t6_tx_idle", tx, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
